// File: rtl/ddr_read_arbiter.sv
// ddr_read_arbiter: shares one DDR read port among bitstream, reference-fetch and display requesters
module ddr_read_arbiter #(
   parameter int ADDR_W = 25,
   parameter int DATA_W = 64,
   parameter int LEN_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ext_mem_init_done,
   input  logic [2:0]        req,
   input  logic              bs_urgent,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [ADDR_W-1:0] addr2,
   input  logic [LEN_W-1:0]  len0,
   input  logic [LEN_W-1:0]  len1,
   input  logic [LEN_W-1:0]  len2,
   output logic [2:0]        gnt,
   output logic [2:0]        done,
   output logic [2:0]        rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              mem_cmd_valid,
   input  logic              mem_cmd_ready,
   output logic [ADDR_W-1:0] mem_cmd_addr,
   output logic [LEN_W-1:0]  mem_cmd_len,
   input  logic              mem_rd_valid,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              stray_beat
);
   localparam logic [1:0] IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2;
   logic [1:0]       state, rr_last, rr_win, win;
   logic [LEN_W-1:0] beat_cnt;
   // cyclic search starting just after the last winner
   always_comb begin
      rr_win = rr_last == 2'd0 ? (req[1] ? 2'd1 : req[2] ? 2'd2 : 2'd0) :
               rr_last == 2'd1 ? (req[2] ? 2'd2 : req[0] ? 2'd0 : 2'd1) :
                                 (req[0] ? 2'd0 : req[1] ? 2'd1 : 2'd2);
      win = (bs_urgent && req[0]) ? 2'd0 : rr_win;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         gnt           <= '0;
         done          <= '0;
         rd_valid      <= '0;
         rd_data       <= '0;
         mem_cmd_valid <= 1'b0;
         mem_cmd_addr  <= '0;
         mem_cmd_len   <= '0;
         stray_beat    <= 1'b0;
         rr_last       <= 2'd2;
         beat_cnt      <= '0;
      end else begin
         done     <= '0;
         rd_valid <= '0;
         if (mem_rd_valid && state != DATA) stray_beat <= 1'b1;
         if (state == IDLE && ext_mem_init_done && |req) begin
            gnt           <= 3'b001 << win;
            mem_cmd_addr  <= win == 2'd0 ? addr0 : win == 2'd1 ? addr1 : addr2;
            mem_cmd_len   <= win == 2'd0 ? len0 : win == 2'd1 ? len1 : len2;
            rr_last       <= win;
            mem_cmd_valid <= 1'b1;
            state         <= CMD;
         end
         if (state == CMD && mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            beat_cnt      <= '0;
            state         <= DATA;
         end
         if (state == DATA && mem_rd_valid) begin
            rd_data  <= mem_rd_data;
            rd_valid <= gnt;
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == mem_cmd_len) begin
               done  <= gnt;
               gnt   <= '0;
               state <= IDLE;
            end
         end
      end
   end
endmodule

// File: tb/tb_ddr_read_arbiter.sv
// tb_ddr_read_arbiter: directed scenarios for ddr_read_arbiter
module tb_ddr_read_arbiter;
   logic        clk = 1'b0, rst = 1'b1, ext_mem_init_done = 1'b0, bs_urgent = 1'b0;
   logic [2:0]  req = '0, gnt, done, rd_valid;
   logic [24:0] addr0 = 25'h000100, addr1 = 25'h000200, addr2 = 25'h000300, mem_cmd_addr;
   logic [4:0]  len0 = 5'd3, len1 = 5'd3, len2 = 5'd3, mem_cmd_len;
   logic [63:0] rd_data, mem_rd_data = '0;
   logic        mem_cmd_valid, mem_cmd_ready = 1'b1, mem_rd_valid = 1'b0, stray_beat;
   int checks = 0, errors = 0;
   int rv_cnt[3] = '{0, 0, 0};
   int dn_cnt[3] = '{0, 0, 0};
   int bad_done = 0, bad_gap = 0, bad_oh = 0;
   logic [2:0] prev_gnt = '0;

   ddr_read_arbiter dut (
      .clk(clk), .rst(rst), .ext_mem_init_done(ext_mem_init_done), .req(req), .bs_urgent(bs_urgent),
      .addr0(addr0), .addr1(addr1), .addr2(addr2), .len0(len0), .len1(len1), .len2(len2),
      .gnt(gnt), .done(done), .rd_valid(rd_valid), .rd_data(rd_data),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_addr(mem_cmd_addr),
      .mem_cmd_len(mem_cmd_len), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
      .stray_beat(stray_beat)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rd_valid[i]) rv_cnt[i]++;
         if (done[i]) dn_cnt[i]++;
      end
      if (done != 0 && done != rd_valid) bad_done++;
      if (prev_gnt != 0 && gnt != 0 && gnt != prev_gnt) bad_gap++;
      if (!$onehot0(gnt) || !$onehot0(done) || !$onehot0(rd_valid)) bad_oh++;
      prev_gnt = gnt;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic grab(output logic [2:0] g);
      int n = 0;
      while (!mem_cmd_valid && n < 50) begin
         tick();
         n++;
      end
      if (!mem_cmd_valid) begin
         errors++;
         $display("FAIL grab_timeout: mem_cmd_valid=%b required 1", mem_cmd_valid);
      end
      g = gnt;
      tick();
   endtask

   task automatic feed(input int n, input bit gappy, input logic [63:0] base);
      for (int i = 0; i < n; i++) begin
         mem_rd_valid = 1'b1;
         mem_rd_data  = base + 64'(i);
         tick();
         mem_rd_valid = 1'b0;
         if (gappy && i < n - 1) tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b required 000", gnt); end
      checks++; if (done !== 3'b000 || rd_valid !== 3'b000) begin errors++; $display("FAIL reset_strobes: done=%b rd_valid=%b required 000", done, rd_valid); end
      checks++; if (mem_cmd_valid !== 1'b0 || stray_beat !== 1'b0) begin errors++; $display("FAIL reset_flags: cmd_valid=%b stray=%b required 0", mem_cmd_valid, stray_beat); end
      checks++; if (rd_data !== 64'd0 || mem_cmd_addr !== 25'd0 || mem_cmd_len !== 5'd0) begin errors++; $display("FAIL reset_data: rd_data=%h addr=%h len=%h required 0", rd_data, mem_cmd_addr, mem_cmd_len); end
   endtask

   task automatic test_init_gating();
      int bad = 0;
      req = 3'b111;
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (gnt !== 3'b000 || mem_cmd_valid !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL init_gate: %0d cycles granted, required 0", bad); end
      ext_mem_init_done = 1'b1;
      tick();
      checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL init_first_gnt: got %b required 001", gnt); end
      checks++; if (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== addr0 || mem_cmd_len !== len0) begin errors++; $display("FAIL init_cmd: valid=%b addr=%h len=%0d required 1 %h %0d", mem_cmd_valid, mem_cmd_addr, mem_cmd_len, addr0, len0); end
      tick();
      feed(4, 1'b0, 64'h100);
      checks++; if (done !== 3'b001 || rd_valid !== 3'b001 || rd_data !== 64'h103) begin errors++; $display("FAIL init_burst_end: done=%b rd_valid=%b data=%h required 001 001 103", done, rd_valid, rd_data); end
   endtask

   task automatic test_round_robin();
      logic [2:0] g;
      logic [2:0] exp_g[3] = '{3'b010, 3'b100, 3'b001};
      for (int k = 0; k < 3; k++) begin
         grab(g);
         checks++; if (g !== exp_g[k]) begin errors++; $display("FAIL rr_order%0d: got %b required %b", k, g, exp_g[k]); end
         feed(4, 1'b0, 64'h200 + 64'(k * 16));
         checks++; if (done !== exp_g[k] || rd_valid !== exp_g[k] || rd_data !== 64'h203 + 64'(k * 16)) begin errors++; $display("FAIL rr_end%0d: done=%b rd_valid=%b data=%h required %b", k, done, rd_valid, rd_data, exp_g[k]); end
      end
      req = 3'b000;
      tick();
      checks++; if (rv_cnt[0] !== 8 || rv_cnt[1] !== 4 || rv_cnt[2] !== 4) begin errors++; $display("FAIL rr_beats: got %0d %0d %0d required 8 4 4", rv_cnt[0], rv_cnt[1], rv_cnt[2]); end
      checks++; if (dn_cnt[0] !== 2 || dn_cnt[1] !== 1 || dn_cnt[2] !== 1) begin errors++; $display("FAIL rr_dones: got %0d %0d %0d required 2 1 1", dn_cnt[0], dn_cnt[1], dn_cnt[2]); end
      checks++; if (stray_beat !== 1'b0) begin errors++; $display("FAIL rr_stray: got %b required 0", stray_beat); end
   endtask

   task automatic test_urgent();
      logic [2:0] g;
      req = 3'b101;
      bs_urgent = 1'b1;
      grab(g);
      bs_urgent = 1'b0;
      checks++; if (g !== 3'b001) begin errors++; $display("FAIL urgent_gnt: got %b required 001", g); end
      feed(4, 1'b0, 64'h500);
      req = 3'b110;
      grab(g);
      checks++; if (g !== 3'b010) begin errors++; $display("FAIL urgent_next_gnt: got %b required 010", g); end
      feed(4, 1'b0, 64'h600);
      req = 3'b000;
      tick();
   endtask

   task automatic test_backpressure();
      int bad = 0;
      mem_cmd_ready = 1'b0;
      addr1 = 25'h1234;
      len1 = 5'd2;
      req = 3'b010;
      tick();
      checks++; if (gnt !== 3'b010 || mem_cmd_valid !== 1'b1) begin errors++; $display("FAIL bp_gnt: gnt=%b valid=%b required 010 1", gnt, mem_cmd_valid); end
      req = 3'b000;
      for (int i = 0; i < 7; i++) begin
         if (i == 3) addr1 = 25'h0BAD;
         tick();
         if (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== 25'h1234 || mem_cmd_len !== 5'd2) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL bp_stable: %0d unstable cycles, required 0", bad); end
      mem_cmd_ready = 1'b1;
      tick();
      checks++; if (mem_cmd_valid !== 1'b0 || gnt !== 3'b010) begin errors++; $display("FAIL bp_accept: valid=%b gnt=%b required 0 010", mem_cmd_valid, gnt); end
      feed(3, 1'b0, 64'h700);
      checks++; if (done !== 3'b010 || rd_data !== 64'h702) begin errors++; $display("FAIL bp_done: done=%b data=%h required 010 702", done, rd_data); end
      tick();
   endtask

   task automatic test_boundary_len();
      logic [2:0] g;
      int rv2, dn2;
      len1 = 5'd0;
      req = 3'b010;
      grab(g);
      checks++; if (g !== 3'b010 || mem_cmd_len !== 5'd0) begin errors++; $display("FAIL len0_cmd: gnt=%b len=%0d required 010 0", g, mem_cmd_len); end
      feed(1, 1'b0, 64'h800);
      checks++; if (rd_valid !== 3'b010 || done !== 3'b010) begin errors++; $display("FAIL len0_done: rd_valid=%b done=%b required 010 010", rd_valid, done); end
      req = 3'b000;
      tick();
      rv2 = rv_cnt[2];
      dn2 = dn_cnt[2];
      len2 = 5'd31;
      req = 3'b100;
      grab(g);
      checks++; if (g !== 3'b100 || mem_cmd_len !== 5'd31) begin errors++; $display("FAIL len31_cmd: gnt=%b len=%0d required 100 31", g, mem_cmd_len); end
      feed(32, 1'b1, 64'h900);
      checks++; if (done !== 3'b100 || rd_data !== 64'h91F) begin errors++; $display("FAIL len31_done: done=%b data=%h required 100 91f", done, rd_data); end
      req = 3'b000;
      tick();
      checks++; if (rv_cnt[2] - rv2 !== 32 || dn_cnt[2] - dn2 !== 1) begin errors++; $display("FAIL len31_counts: beats=%0d dones=%0d required 32 1", rv_cnt[2] - rv2, dn_cnt[2] - dn2); end
   endtask

   task automatic test_stray_reset();
      logic [2:0] g;
      int rv_tot, rv0, dn0;
      checks++; if (stray_beat !== 1'b0) begin errors++; $display("FAIL stray_pre: got %b required 0", stray_beat); end
      rv_tot = rv_cnt[0] + rv_cnt[1] + rv_cnt[2];
      mem_rd_valid = 1'b1;
      tick();
      mem_rd_valid = 1'b0;
      tick();
      checks++; if (stray_beat !== 1'b1) begin errors++; $display("FAIL stray_idle: got %b required 1", stray_beat); end
      checks++; if (rv_cnt[0] + rv_cnt[1] + rv_cnt[2] !== rv_tot) begin errors++; $display("FAIL stray_no_valid: got %0d beats required %0d", rv_cnt[0] + rv_cnt[1] + rv_cnt[2], rv_tot); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (stray_beat !== 1'b0) begin errors++; $display("FAIL stray_clear: got %b required 0", stray_beat); end
      len0 = 5'd7;
      req = 3'b001;
      rv0 = rv_cnt[0];
      dn0 = dn_cnt[0];
      grab(g);
      checks++; if (g !== 3'b001) begin errors++; $display("FAIL midrst_gnt: got %b required 001", g); end
      feed(5, 1'b0, 64'hA00);
      rst = 1'b1;
      req = 3'b000;
      tick();
      rst = 1'b0;
      checks++; if (gnt !== 3'b000 || done !== 3'b000 || rd_valid !== 3'b000) begin errors++; $display("FAIL midrst_abort: gnt=%b done=%b rd_valid=%b required 000", gnt, done, rd_valid); end
      feed(3, 1'b0, 64'hA05);
      tick();
      checks++; if (stray_beat !== 1'b1) begin errors++; $display("FAIL midrst_stray: got %b required 1", stray_beat); end
      checks++; if (rv_cnt[0] - rv0 !== 5 || dn_cnt[0] - dn0 !== 0) begin errors++; $display("FAIL midrst_counts: beats=%0d dones=%0d required 5 0", rv_cnt[0] - rv0, dn_cnt[0] - dn0); end
   endtask

   task automatic test_invariants();
      checks++; if (bad_done !== 0) begin errors++; $display("FAIL done_with_last_beat: %0d violations required 0", bad_done); end
      checks++; if (bad_gap !== 0) begin errors++; $display("FAIL dead_cycle: %0d violations required 0", bad_gap); end
      checks++; if (bad_oh !== 0) begin errors++; $display("FAIL onehot: %0d violations required 0", bad_oh); end
   endtask

   initial begin
      test_reset();
      test_init_gating();
      test_round_robin();
      test_urgent();
      test_backpressure();
      test_boundary_len();
      test_stray_reset();
      test_invariants();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
